serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor that computes a - b one bit per clock, LSB first. It uses a single full-subtractor cell and a registered borrow, mirroring the team's full-adder cell in the opposite arithmetic direction. It sits beside the ALU as a low-area datapath option. Operands enter and results leave through valid/ready handshakes.

Parameters:
WIDTH, 32, operand and result width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
start_valid  input  1  operands a/b valid
start_ready  output  1  block can accept operands
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
result_valid  output  1  result fields valid
result_ready  input  1  consumer accepts result
difference  output  WIDTH  a - b modulo 2^WIDTH
borrowout  output  1  final borrow; 1 iff a < b unsigned
overflow  output  1  signed overflow of a - b
zero  output  1  difference == 0

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, takes effect immediately, no clock needed):
  - state = IDLE
  - start_ready=0 while rst_n=0, then 1 from the first cycle after release
  - result_valid=0, difference=0, borrowout=0, overflow=0, zero=0
  - internal shift registers, borrow and counter cleared
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start_ready=1, result_valid=0.
  - On an edge with start_valid=1: latch a and b into shift registers, borrow=0, count=0, save a[WIDTH-1] and b[WIDTH-1], go to SHIFT.
- SHIFT:
  - start_ready=0, result_valid=0.
  - Each edge, with x=a_sh[0], y=b_sh[0], c=borrow:
    - d = x^y^c
    - borrow_next = (~x&y) | (~(x^y)&c)
    - shift a_sh and b_sh right by 1
    - shift d into the MSB of the diff register
    - count++
  - On the edge processing bit WIDTH-1 (count==WIDTH-1), go to DONE.
  - a and b inputs are ignored during SHIFT; changing them has no effect.
- DONE:
  - result_valid=1.
  - difference = diff register.
  - borrowout = final borrow.
  - overflow = (a_msb != b_msb) && (difference[WIDTH-1] != a_msb).
  - zero = (difference == 0).
  - All result outputs are held stable until an edge with result_ready=1, which returns the FSM to IDLE.
  - start_valid is ignored in DONE.
- Latency:
  - result_valid rises exactly WIDTH cycles after the accepting edge.
  - Minimum issue interval is WIDTH+2 cycles: accept, WIDTH shifts, drain, with start_ready returning the cycle after the result handshake.
- Result outputs may be driven combinationally from registers or registered. They must read 0 whenever result_valid=0 outside DONE.
- result_ready held high in advance is legal. The result is consumed on the first DONE edge, so result_valid is high for exactly one cycle.
- No overlap: a new operand is never accepted in the same cycle a result is consumed.
- Reset mid-operation (SHIFT or DONE): the in-flight result is discarded, all outputs go to reset values immediately, and no result_valid pulse follows.
- All arithmetic is modulo 2^WIDTH. Borrow out of the MSB appears only on borrowout.

Test Plan:
1. WIDTH=8, a=0x05, b=0x03, result_ready=1 -> result_valid exactly 8 cycles after accept; difference=0x02, borrowout=0, overflow=0, zero=0.
2. WIDTH=8, a=0x03, b=0x05 -> difference=0xFE, borrowout=1, overflow=0, zero=0. WIDTH=32, a=0, b=1 -> 0xFFFFFFFF, borrowout=1, overflow=0.
3. WIDTH=8, a=0x80, b=0x01 -> difference=0x7F, overflow=1, borrowout=0. Also a=0x7F, b=0xFF -> difference=0x80, overflow=1, borrowout=1.
4. WIDTH=8, a=b=0x5A -> difference=0x00, zero=1, borrowout=0, overflow=0.
5. Backpressure: hold result_ready=0 for 5 cycles in DONE with start_valid=1 and toggling a/b -> outputs constant, start_ready=0, nothing accepted. Then result_ready=1 -> IDLE, and the next operand pair is accepted one cycle later.
6. Drop rst_n during the 3rd SHIFT cycle -> all outputs 0 immediately. After release, start_ready=1; the next op a=0x10, b=0x01 yields 0x0F with no stale result_valid.

Source files
------------

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, LSB first
module serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] difference,
    output logic             borrowout,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    count;
    logic             borrow;
    logic             a_msb;
    logic             b_msb;
    logic             armed;

    logic x, y, d, borrow_next, in_done;

    // Single full-subtractor cell on the current LSBs and the registered borrow
    always_comb begin
        x           = a_sh[0];
        y           = b_sh[0];
        d           = x ^ y ^ borrow;
        borrow_next = (~x & y) | (~(x ^ y) & borrow);
    end

    // armed keeps start_ready low until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            diff_q <= '0;
            count  <= '0;
            borrow <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            armed  <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (start_valid && start_ready) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= 1'b0;
                        count  <= '0;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    diff_q <= {d, diff_q[WIDTH-1:1]};
                    borrow <= borrow_next;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Result fields are forced to zero whenever no result is being presented
    always_comb begin
        in_done      = (state == DONE);
        start_ready  = armed && (state == IDLE);
        result_valid = in_done;
        difference   = in_done ? diff_q : '0;
        borrowout    = in_done && borrow;
        overflow     = in_done && (a_msb != b_msb) && (diff_q[WIDTH-1] != a_msb);
        zero         = in_done && (diff_q == '0);
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         result_valid;
    logic         result_ready = 1'b0;
    logic [W-1:0] difference;
    logic         borrowout;
    logic         overflow;
    logic         zero;

    logic         sv32 = 1'b0;
    logic         sr32;
    logic [31:0]  a32 = '0;
    logic [31:0]  b32 = '0;
    logic         rv32;
    logic         rr32 = 1'b0;
    logic [31:0]  d32;
    logic         bo32, ov32, z32;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           due;
        bit           seen;
    } op_t;
    op_t q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b),
        .result_valid(result_valid), .result_ready(result_ready),
        .difference(difference), .borrowout(borrowout),
        .overflow(overflow), .zero(zero)
    );

    serial_subtractor #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .start_valid(sv32), .start_ready(sr32),
        .a(a32), .b(b32),
        .result_valid(rv32), .result_ready(rr32),
        .difference(d32), .borrowout(bo32),
        .overflow(ov32), .zero(z32)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit ovf_model(input longint sa, input longint sb, input int width);
        longint r, lim;
        r   = sa - sb;
        lim = longint'(1) << (width - 1);
        return (r >= lim) || (r < -lim);
    endfunction

    // Reference check on every falling edge: reset values, idle zeros, results vs arithmetic
    always @(negedge clk) begin
        logic [W-1:0] ed;
        if (!rst_n) begin
            chk("reset_outs", {start_ready, result_valid, difference, borrowout, overflow, zero}, 64'd0);
            q.delete();
        end else begin
            if (result_valid) begin
                if (q.size() == 0) begin
                    chk("stale_valid", 64'd1, 64'd0);
                end else begin
                    if (!q[0].seen) begin
                        chk("latency", 64'(cyc), 64'(q[0].due));
                        q[0].seen = 1;
                    end
                    ed = q[0].a - q[0].b;
                    chk("difference", difference, ed);
                    chk("borrowout", borrowout, (q[0].a < q[0].b));
                    chk("overflow", overflow,
                        ovf_model(longint'($signed(q[0].a)), longint'($signed(q[0].b)), W));
                    chk("zero", zero, (ed == 0));
                    chk("ready_in_done", start_ready, 64'd0);
                    if (result_ready) void'(q.pop_front());
                end
            end else begin
                chk("idle_outs_zero", {difference, borrowout, overflow, zero}, 64'd0);
                if (q.size() != 0 && !q[0].seen && cyc >= q[0].due)
                    chk("valid_missing", 64'd0, 64'd1);
            end
            if (start_valid && start_ready)
                q.push_back('{a: a, b: b, due: cyc + 1 + W, seen: 0});
        end
    end

    // Issue one operation, hold the result for 'hold' cycles, return what was seen
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input int hold,
                         output logic [W-1:0] od, output logic ob, output logic oo,
                         output logic oz, output int lat);
        int n = 0;
        while (!start_ready && n < 50) begin step(); n++; end
        if (!start_ready) chk("start_ready_timeout", 64'd0, 64'd1);
        a = ia; b = ib; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        a = W'($urandom); b = W'($urandom);
        result_ready = (hold == 0);
        lat = 0;
        while (!result_valid && lat < 100) begin
            step();
            lat++;
            a = W'($urandom); b = W'($urandom);
        end
        if (!result_valid) chk("result_timeout", 64'd0, 64'd1);
        od = difference; ob = borrowout; oo = overflow; oz = zero;
        repeat (hold) step();
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
    endtask

    task automatic lit(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] xd, input logic xb, input logic xo, input logic xz);
        logic [W-1:0] od;
        logic ob, oo, oz;
        int lat;
        do_op(ia, ib, 0, od, ob, oo, oz, lat);
        chk({name, "_lat"}, 64'(lat), 64'(W));
        chk({name, "_diff"}, od, xd);
        chk({name, "_flags"}, {ob, oo, oz}, {xb, xo, xz});
    endtask

    task automatic op32(input logic [31:0] ia, input logic [31:0] ib);
        int lat = 0;
        logic [31:0] xd;
        while (!sr32 && lat < 50) begin step(); lat++; end
        a32 = ia; b32 = ib; sv32 = 1'b1;
        step();
        sv32 = 1'b0; rr32 = 1'b1;
        lat = 0;
        while (!rv32 && lat < 100) begin step(); lat++; end
        xd = ia - ib;
        chk("w32_lat", 64'(lat), 64'd32);
        chk("w32_diff", d32, xd);
        chk("w32_borrow", bo32, (ia < ib));
        chk("w32_ovf", ov32, ovf_model(longint'($signed(ia)), longint'($signed(ib)), 32));
        chk("w32_zero", z32, (xd == 0));
        step();
        rr32 = 1'b0;
    endtask

    initial begin
        logic [W-1:0] od, ra, rb;
        logic ob, oo, oz;
        int lat;
        logic [W-1:0] specials [5];
        specials = '{8'h00, 8'h7F, 8'h80, 8'hFF, 8'h01};

        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("ready_after_reset", start_ready, 64'd1);

        lit("sub_05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
        lit("sub_03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
        lit("sub_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
        lit("sub_7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
        lit("sub_5a_5a", 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1);

        // Backpressure in DONE with start_valid held and operands toggling
        a = 8'h33; b = 8'h44; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        lat = 0;
        while (!result_valid && lat < 100) begin step(); lat++; end
        od = difference;
        for (int i = 0; i < 5; i++) begin
            start_valid = 1'b1; a = W'($urandom); b = W'($urandom);
            step();
            chk("bp_ready_low", start_ready, 64'd0);
            chk("bp_held", difference, od);
        end
        a = 8'h21; b = 8'h12; result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        chk("bp_ready_back", start_ready, 64'd1);
        step();
        start_valid = 1'b0;
        chk("bp_accepted", start_ready, 64'd0);
        lat = 0;
        while (!result_valid && lat < 100) begin step(); lat++; end
        chk("bp_next_diff", difference, 8'h0F);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;

        // Reset during the third shift cycle
        while (!start_ready) step();
        a = 8'h40; b = 8'h02; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1 chk("mid_reset_outs", {start_ready, result_valid, difference, borrowout, overflow, zero}, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("ready_after_mid_reset", start_ready, 64'd1);
        do_op(8'h10, 8'h01, 1, od, ob, oo, oz, lat);
        chk("post_reset_diff", od, 8'h0F);
        chk("post_reset_lat", 64'(lat), 64'(W));

        // Randomised operations with random backpressure and idle gaps
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : W'($urandom);
            if ($urandom_range(0, 9) == 0) rb = ra;
            do_op(ra, rb, $urandom_range(0, 3), od, ob, oo, oz, lat);
            repeat ($urandom_range(0, 2)) step();
        end

        op32(32'h0, 32'h1);
        op32(32'h8000_0000, 32'h1);
        for (int i = 0; i < 3; i++) op32($urandom, $urandom);

        step();
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
